// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous data RAM between
// NUM_REQ requesters. Each access takes two cycles: an arbitration edge that
// registers the winner onto the RAM lines and raises gnt, then a BUSY cycle
// closed by the edge at which the RAM samples. Reads return rvalid with rdata
// passed straight through from the RAM one cycle later.
// Optional feature: define RAM_ARB_LOCK_EN to add the lock port, which lets a
// requester hold the RAM across several back-to-back accesses.
module ram_port_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
`ifdef RAM_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        lock,
`endif
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic [ADDR_W-1:0]         ram_address,
    output logic                      ram_we,
    output logic [DATA_W-1:0]         ram_wdata,
    input  logic [DATA_W-1:0]         ram_rdata
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e               state_q, state_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]     win_q, win_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   rvalid_q, rvalid_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 we_q, we_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;

    logic                 any_req;
    logic [PTR_W-1:0]     win;
    logic [PTR_W-1:0]     ptr_next;
    logic                 hold;

`ifdef RAM_ARB_LOCK_EN
    logic                 locked_q, locked_d;
    logic [PTR_W-1:0]     owner_q, owner_d;
`endif

    // Round-robin search from rr_ptr with explicit wrap; a held lock overrides it.
    always_comb begin
        logic [PTR_W:0] sum;
        any_req = 1'b0;
        win     = '0;
        hold    = 1'b0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_REQ)) begin
                sum = sum - (PTR_W+1)'(NUM_REQ);
            end
            if (!any_req && req[sum[PTR_W-1:0]]) begin
                any_req = 1'b1;
                win     = sum[PTR_W-1:0];
            end
        end
`ifdef RAM_ARB_LOCK_EN
        hold = locked_q && lock[owner_q] && req[owner_q];
        if (hold) begin
            any_req = 1'b1;
            win     = owner_q;
        end
`endif
        if (win == PTR_W'(NUM_REQ - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = win + PTR_W'(1);
        end
    end

    // Next-state: grant on an IDLE edge, release RAM lines and return read on the BUSY edge.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        win_d    = win_q;
        gnt_d    = '0;
        rvalid_d = '0;
        addr_d   = addr_q;
        we_d     = 1'b0;
        wdata_d  = wdata_q;
`ifdef RAM_ARB_LOCK_EN
        locked_d = locked_q;
        owner_d  = owner_q;
`endif
        unique case (state_q)
            StIdle: begin
`ifdef RAM_ARB_LOCK_EN
                if (!hold) begin
                    locked_d = 1'b0;
                end
`endif
                if (any_req) begin
                    for (int i = 0; i < int'(NUM_REQ); i++) begin
                        if (win == PTR_W'(i)) begin
                            addr_d  = req_addr[i*ADDR_W +: ADDR_W];
                            wdata_d = req_wdata[i*DATA_W +: DATA_W];
                            we_d    = req_we[i];
                        end
                    end
                    gnt_d[win] = 1'b1;
                    win_d      = win;
                    // A held lock freezes the pointer so round-robin resumes where it left off.
                    rr_ptr_d   = hold ? rr_ptr_q : ptr_next;
                    state_d    = StBusy;
`ifdef RAM_ARB_LOCK_EN
                    locked_d   = lock[win];
                    owner_d    = win;
`endif
                end
            end
            StBusy: begin
                if (!we_q) begin
                    rvalid_d[win_q] = 1'b1;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            win_q    <= '0;
            gnt_q    <= '0;
            rvalid_q <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
`ifdef RAM_ARB_LOCK_EN
            locked_q <= 1'b0;
            owner_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            win_q    <= win_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
`ifdef RAM_ARB_LOCK_EN
            locked_q <= locked_d;
            owner_q  <= owner_d;
`endif
        end
    end

    assign gnt         = gnt_q;
    assign rvalid      = rvalid_q;
    assign rdata       = ram_rdata;
    assign ram_address = addr_q;
    assign ram_we      = we_q;
    assign ram_wdata   = wdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural synchronous RAM.
// Inputs change 1 ns after each rising edge; outputs are checked at that point.
module tb_ram_port_arbiter;

    localparam int unsigned NR = 3;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR-1:0]     req_we;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
`ifdef RAM_ARB_LOCK_EN
    logic [NR-1:0]     lock;
`endif
    logic [NR-1:0]     gnt;
    logic [NR-1:0]     rvalid;
    logic [DW-1:0]     rdata;
    logic [AW-1:0]     ram_address;
    logic              ram_we;
    logic [DW-1:0]     ram_wdata;
    logic [DW-1:0]     ram_rdata;

    logic [DW-1:0]     mem [0:255];

    int n_tests = 0;
    int n_fail  = 0;

    ram_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
`ifdef RAM_ARB_LOCK_EN
        .lock        (lock),
`endif
        .gnt         (gnt),
        .rvalid      (rvalid),
        .rdata       (rdata),
        .ram_address (ram_address),
        .ram_we      (ram_we),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM: address sampled at the edge, data valid the following cycle.
    always @(posedge clk) begin
        if (ram_we) mem[ram_address[7:0]] <= ram_wdata;
        ram_rdata <= mem[ram_address[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req_we[i]             = we;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    initial begin
        logic [NR-1:0] exp_gnt [0:5];
        exp_gnt[0] = 3'b001;
        exp_gnt[1] = 3'b010;
        exp_gnt[2] = 3'b100;
        exp_gnt[3] = 3'b001;
        exp_gnt[4] = 3'b010;
        exp_gnt[5] = 3'b100;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 16'hBEEF;
        mem[8'h11] = 16'hCAFE;
        ram_rdata = '0;
        rst = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
`ifdef RAM_ARB_LOCK_EN
        lock = '0;
`endif
        tick();
        tick();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_rvalid", 32'(rvalid), 32'h0);
        check("rst_we", 32'(ram_we), 32'h0);
        check("rst_addr", 32'(ram_address), 32'h0);
        check("rst_wdata", 32'(ram_wdata), 32'h0);
        rst = 1'b0;

        // Single read by requester 0.
        set_req(0, 1'b0, 16'h0010, 16'h0);
        req = 3'b001;
        tick();
        check("rd_gnt", 32'(gnt), 32'h1);
        check("rd_addr", 32'(ram_address), 32'h0010);
        check("rd_we", 32'(ram_we), 32'h0);
        req = '0;
        tick();
        check("rd_gnt_drop", 32'(gnt), 32'h0);
        check("rd_rvalid", 32'(rvalid), 32'h1);
        check("rd_rdata", 32'(rdata), 32'hBEEF);
        check("rd_we2", 32'(ram_we), 32'h0);
        tick();
        check("rd_rvalid_drop", 32'(rvalid), 32'h0);

        // Write by requester 1, then read it back through requester 0.
        set_req(1, 1'b1, 16'h0004, 16'h1234);
        req = 3'b010;
        tick();
        check("wr_gnt", 32'(gnt), 32'h2);
        check("wr_we", 32'(ram_we), 32'h1);
        check("wr_addr", 32'(ram_address), 32'h0004);
        check("wr_wdata", 32'(ram_wdata), 32'h1234);
        req = '0;
        tick();
        check("wr_we_drop", 32'(ram_we), 32'h0);
        check("wr_no_rvalid", 32'(rvalid), 32'h0);
        tick();
        check("wr_no_rvalid2", 32'(rvalid), 32'h0);
        set_req(0, 1'b0, 16'h0004, 16'h0);
        req = 3'b001;
        tick();
        check("rb_gnt", 32'(gnt), 32'h1);
        req = '0;
        tick();
        check("rb_rvalid", 32'(rvalid), 32'h1);
        check("rb_rdata", 32'(rdata), 32'h1234);
        tick();

        // All three requesting continuously: strict rotation, one grant every 2 cycles.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, 1'b0, 16'h0010, 16'h0);
        set_req(1, 1'b0, 16'h0011, 16'h0);
        set_req(2, 1'b0, 16'h0004, 16'h0);
        req = 3'b111;
        for (int c = 0; c < 12; c++) begin
            tick();
            check($sformatf("rr_gnt%0d", c), 32'(gnt),
                  (c % 2 == 0) ? 32'(exp_gnt[c/2]) : 32'h0);
        end
        req = '0;
        tick();

        // Reset landing in the BUSY cycle of a write.
        set_req(0, 1'b1, 16'h0020, 16'h5555);
        req = 3'b001;
        tick();
        check("rb_busy_we", 32'(ram_we), 32'h1);
        rst = 1'b1;
        req = '0;
        tick();
        check("rb_abort_we", 32'(ram_we), 32'h0);
        check("rb_abort_gnt", 32'(gnt), 32'h0);
        check("rb_abort_rvalid", 32'(rvalid), 32'h0);
        rst = 1'b0;
        set_req(0, 1'b0, 16'h0010, 16'h0);
        set_req(1, 1'b0, 16'h0011, 16'h0);
        set_req(2, 1'b0, 16'h0010, 16'h0);
        req = 3'b110;
        tick();
        check("rb_next_gnt", 32'(gnt), 32'h2);
        req = '0;
        tick();
        check("rb_next_rvalid", 32'(rvalid), 32'h2);
        check("rb_next_rdata", 32'(rdata), 32'hCAFE);
        tick();

        // Back-to-back reads: requester 1 is granted at the end of requester 0's rvalid cycle.
        req = 3'b011;
        tick();
        check("b2b_gnt0", 32'(gnt), 32'h1);
        req = 3'b010;
        tick();
        check("b2b_rvalid0", 32'(rvalid), 32'h1);
        check("b2b_rdata0", 32'(rdata), 32'hBEEF);
        check("b2b_gap", 32'(gnt), 32'h0);
        tick();
        check("b2b_gnt1", 32'(gnt), 32'h2);
        check("b2b_addr1", 32'(ram_address), 32'h0011);
        req = '0;
        tick();
        check("b2b_rvalid1", 32'(rvalid), 32'h2);
        check("b2b_rdata1", 32'(rdata), 32'hCAFE);
        tick();

`ifdef RAM_ARB_LOCK_EN
        // Requester 2 locks for three accesses while requester 0 waits.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        lock = 3'b100;
        req  = 3'b100;
        tick();
        check("lk_gnt_a", 32'(gnt), 32'h4);
        req = 3'b101;
        tick();
        tick();
        check("lk_gnt_b", 32'(gnt), 32'h4);
        tick();
        tick();
        check("lk_gnt_c", 32'(gnt), 32'h4);
        lock = '0;
        req  = 3'b001;
        tick();
        tick();
        check("lk_gnt_rel", 32'(gnt), 32'h1);
        req = '0;
        tick();
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
